// File: rtl/cache_ctrl_pkg.sv
// Shared geometry, line layout and controller states for the direct-mapped
// write-through data cache controller.
package cache_ctrl_pkg;
  localparam int WORD_SIZE      = 32;
  localparam int ADDR_W         = 32;
  localparam int INDEX_BITS     = 5;
  localparam int BLOCK_OFFSET   = 6;
  localparam int TAG_BITS       = ADDR_W - INDEX_BITS - BLOCK_OFFSET;
  localparam int WORDS_PER_LINE = 2 ** (BLOCK_OFFSET - 2);
  localparam int LINE_LENGTH    = TAG_BITS + WORDS_PER_LINE * WORD_SIZE + 1;
  localparam int CNT_W          = $clog2(WORDS_PER_LINE);

  // Installed line: {tag, w15..w0, valid}
  localparam int LINE_TAG_MSB   = LINE_LENGTH - 1;
  localparam int LINE_TAG_LSB   = LINE_LENGTH - TAG_BITS;
  localparam int LINE_VALID_BIT = 0;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, RDREQ, REFILL, FILL, MEMWR, RESP
  } state_t;

  function automatic int word_base(input int k);
    return k * WORD_SIZE + 1;
  endfunction
endpackage

// File: rtl/line_refill_buffer.sv
// Collects the refill burst word by word and presents it packed as an
// installable cache line.
module line_refill_buffer
  import cache_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_load,
  input  logic [WORD_SIZE-1:0]   i_data,
  input  logic [TAG_BITS-1:0]    i_tag,
  output logic                   o_done,
  output logic [LINE_LENGTH-1:0] o_line
);
  logic [CNT_W-1:0]                          r_cnt;
  logic [WORDS_PER_LINE-1:0][WORD_SIZE-1:0]  r_words;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_words <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_words[r_cnt] <= i_data;
      r_cnt          <= r_cnt + 1'b1;  // wraps to 0 on the last beat
    end
  end

  assign o_done = i_load && (r_cnt == CNT_W'(WORDS_PER_LINE - 1));
  // Packed word 0 sits right above the valid bit, matching the line layout.
  assign o_line = {i_tag, r_words, 1'b1};
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache sequencer between the
// CPU load/store port, the cache array and main memory.
module dcache_controller
  import cache_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_ready,
  output logic [ADDR_W-1:0]      c_addr,
  output logic [WORD_SIZE-1:0]   c_data_in,
  output logic [LINE_LENGTH-1:0] c_line,
  output logic                   c_full_line_wr,
  output logic                   c_wr,
  output logic                   c_re,
  output logic                   c_en,
  input  logic                   c_hit,
  input  logic [WORD_SIZE-1:0]   c_data_out,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [WORD_SIZE-1:0]   mem_wdata,
  input  logic                   mem_gnt,
  input  logic                   mem_rvalid,
  input  logic [WORD_SIZE-1:0]   mem_rdata
);
  state_t                 r_state, w_next;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_we;
  logic [WORD_SIZE-1:0]   r_wdata;
  logic [WORD_SIZE-1:0]   r_hit_data;
  logic [WORD_SIZE-1:0]   r_cpu_rdata;
  logic                   r_cpu_ready;
  logic                   w_buf_clear, w_buf_load, w_buf_done;
  logic [LINE_LENGTH-1:0] w_line;

  line_refill_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_buf_clear),
    .i_load  (w_buf_load),
    .i_data  (mem_rdata),
    .i_tag   (r_addr[ADDR_W-1 -: TAG_BITS]),
    .o_done  (w_buf_done),
    .o_line  (w_line)
  );

  // The accept guard keeps a request still held during the ready pulse from
  // being taken a second time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_hit_data  <= '0;
      r_cpu_rdata <= '0;
      r_cpu_ready <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cpu_ready <= (r_state == RESP);
      if (r_state == IDLE && cpu_req && !r_cpu_ready) begin
        r_addr  <= cpu_addr;
        r_we    <= cpu_we;
        r_wdata <= cpu_wdata;
      end
      if (r_state == LOOKUP && !r_we && c_hit) r_hit_data <= c_data_out;
      if (r_state == RESP && !r_we) r_cpu_rdata <= r_hit_data;
    end
  end

  always_comb begin
    w_next         = r_state;
    c_en           = 1'b0;
    c_re           = 1'b0;
    c_wr           = 1'b0;
    c_full_line_wr = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    w_buf_clear    = 1'b0;
    w_buf_load     = 1'b0;
    case (r_state)
      IDLE:   if (cpu_req && !r_cpu_ready) w_next = LOOKUP;
      LOOKUP: begin
        c_en = 1'b1;
        c_re = ~r_we;
        if (r_we) begin
          c_wr   = c_hit;
          w_next = MEMWR;
        end else begin
          w_next = c_hit ? RESP : RDREQ;
        end
      end
      RDREQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[ADDR_W-1:BLOCK_OFFSET], {BLOCK_OFFSET{1'b0}}};
        if (mem_gnt) begin
          w_buf_clear = 1'b1;
          w_next      = REFILL;
        end
      end
      REFILL: begin
        w_buf_load = mem_rvalid;
        if (w_buf_done) w_next = FILL;
      end
      FILL: begin
        c_en           = 1'b1;
        c_full_line_wr = 1'b1;
        w_next         = LOOKUP;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
        if (mem_gnt) w_next = RESP;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign cpu_rdata = r_cpu_rdata;
  assign cpu_ready = r_cpu_ready;
  assign c_addr    = r_addr;
  assign c_data_in = r_wdata;
  assign c_line    = c_full_line_wr ? w_line : '0;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench: behavioural cache array and burst memory around the
// controller, table of CPU transactions plus refill and abort sequences.
module tb_dcache_controller;
  import cache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic cpu_req, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [31:0] c_addr, c_data_in, c_data_out;
  logic [LINE_LENGTH-1:0] c_line;
  logic c_full_line_wr, c_wr, c_re, c_en, c_hit;
  logic mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .c_addr(c_addr), .c_data_in(c_data_in), .c_line(c_line),
    .c_full_line_wr(c_full_line_wr), .c_wr(c_wr), .c_re(c_re), .c_en(c_en),
    .c_hit(c_hit), .c_data_out(c_data_out), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // Cache array model: combinational hit/read, line install and word write at the edge.
  bit                  cv[32];
  logic [TAG_BITS-1:0] ctag[32];
  logic [31:0]         cdata[32][16];
  logic [4:0]          w_idx;
  logic [3:0]          w_wd;
  int fill_cnt = 0, cwr_cnt = 0, both_err = 0, wr_rule_err = 0;
  logic [LINE_LENGTH-1:0] last_line;

  assign w_idx      = c_addr[10:6];
  assign w_wd       = c_addr[5:2];
  assign c_hit      = c_en && cv[w_idx] && (ctag[w_idx] == c_addr[31:11]);
  assign c_data_out = cdata[w_idx][w_wd];

  always @(posedge clk) begin
    if (c_full_line_wr) begin
      fill_cnt       <= fill_cnt + 1;
      last_line      <= c_line;
      cv[w_idx]      <= c_line[LINE_VALID_BIT];
      ctag[w_idx]    <= c_line[LINE_TAG_MSB:LINE_TAG_LSB];
      for (int k = 0; k < 16; k++) cdata[w_idx][k] <= c_line[k*32+1 +: 32];
    end
    if (c_wr) begin
      cwr_cnt            <= cwr_cnt + 1;
      cdata[w_idx][w_wd] <= c_data_in;
      if (!c_hit || c_re) wr_rule_err <= wr_rule_err + 1;
    end
    if (c_wr && c_full_line_wr) both_err <= both_err + 1;
  end

  // Memory model: grant after gnt_delay waiting cycles, 16 back-to-back beats on reads.
  logic [31:0] memw [bit [31:0]];
  int gnt_delay = 0, wait_cnt = 0, rd_beat = 0, mem_rd_cnt = 0, mem_wr_cnt = 0;
  bit rd_pending = 0;
  logic [31:0] rd_base, last_wr_addr, last_wr_data, last_rd_addr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (memw.exists(a)) return memw[a];
    return 32'h90 + {2'b00, a[31:2]};
  endfunction

  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 0; mem_rvalid = 0;
      if (rst) begin
        rd_pending = 0; wait_cnt = 0;
      end else if (rd_pending) begin
        mem_rvalid = 1;
        mem_rdata  = mem_rd(rd_base + 32'(rd_beat * 4));
        rd_beat++;
        if (rd_beat == 16) rd_pending = 0;
      end else if (mem_req) begin
        if (wait_cnt < gnt_delay) wait_cnt++;
        else begin
          wait_cnt = 0; mem_gnt = 1;
          if (mem_we) begin
            memw[mem_addr] = mem_wdata; mem_wr_cnt++;
            last_wr_addr = mem_addr; last_wr_data = mem_wdata;
          end else begin
            mem_rd_cnt++; last_rd_addr = mem_addr;
            rd_base = mem_addr; rd_beat = 0; rd_pending = 1;
          end
        end
      end
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic outs_nonzero();
    return |{cpu_rdata, cpu_ready, c_addr, c_data_in, c_line, c_full_line_wr, c_wr,
             c_re, c_en, mem_req, mem_we, mem_addr, mem_wdata};
  endfunction

  // Issue one request at a negedge; latency counts cycles until cpu_ready.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd);
    @(negedge clk);
    cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1; lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_ready) break;
    end
    rd = cpu_rdata;
    cpu_req = 0;
    if (!cpu_ready) begin
      n_chk++; n_err++;
      $display("FAIL timeout addr %0h: got no cpu_ready expected ready within 200 cycles", a);
    end
  endtask

  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; int gdly;
    logic [31:0] exp_rd; int exp_lat;
    int d_mrd; int d_mwr; int d_fill; int d_cwr; logic [31:0] exp_maddr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int lat, mrd0, mwr0, f0, cw0, r0;
    logic [31:0] rd;
    bit reached;
    int ready_seen;

    vecs[0] = '{0, 32'h0000_0044, 32'h0,         0, 32'h0000_00A1,  3, 0, 0, 0, 0, 32'h0};
    vecs[1] = '{1, 32'h0000_0048, 32'hDEADBEEF,  0, 32'h0,          4, 0, 1, 0, 1, 32'h0000_0048};
    vecs[2] = '{0, 32'h0000_0048, 32'h0,         0, 32'hDEADBEEF,   3, 0, 0, 0, 0, 32'h0};
    vecs[3] = '{1, 32'h0001_0000, 32'h12345678,  0, 32'h0,          4, 0, 1, 0, 0, 32'h0001_0000};
    vecs[4] = '{0, 32'h0001_0000, 32'h0,         0, 32'h12345678,  22, 1, 0, 1, 0, 32'h0001_0000};
    vecs[5] = '{0, 32'h0800_0044, 32'h0,         0, 32'h0200_00A1, 22, 1, 0, 1, 0, 32'h0800_0040};
    vecs[6] = '{0, 32'h0000_0040, 32'h0,         0, 32'h0000_00A0, 22, 1, 0, 1, 0, 32'h0000_0040};
    vecs[7] = '{0, 32'h0000_007C, 32'h0,         0, 32'h0000_00AF,  3, 0, 0, 0, 0, 32'h0};
    vecs[8] = '{1, 32'h0000_007C, 32'h00000055,  2, 32'h0,          6, 0, 1, 0, 1, 32'h0000_007C};
    vecs[9] = '{0, 32'h0000_007C, 32'h0,         0, 32'h0000_0055,  3, 0, 0, 0, 0, 32'h0};

    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", outs_nonzero(), 0);
    rst = 0;

    // Cold read: full refill and install of line 0x40.
    mrd0 = mem_rd_cnt; f0 = fill_cnt;
    do_req(0, 32'h0000_0040, 0, lat, rd);
    chk("cold_rdata", rd, 32'hA0);
    chk("cold_latency", lat, 22);
    chk("cold_mem_reads", mem_rd_cnt - mrd0, 1);
    chk("cold_mem_addr", last_rd_addr, 32'h40);
    chk("cold_fills", fill_cnt - f0, 1);
    chk("cold_line_valid", last_line[LINE_VALID_BIT], 1);
    chk("cold_line_tag", last_line[LINE_TAG_MSB:LINE_TAG_LSB], 0);
    for (int k = 0; k < 16; k++)
      chk($sformatf("cold_line_w%0d", k), last_line[word_base(k) +: 32], 32'hA0 + 32'(k));

    foreach (vecs[i]) begin
      gnt_delay = vecs[i].gdly;
      mrd0 = mem_rd_cnt; mwr0 = mem_wr_cnt; f0 = fill_cnt; cw0 = cwr_cnt;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
      if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_mem_reads", i), mem_rd_cnt - mrd0, vecs[i].d_mrd);
      chk($sformatf("v%0d_mem_writes", i), mem_wr_cnt - mwr0, vecs[i].d_mwr);
      chk($sformatf("v%0d_fills", i), fill_cnt - f0, vecs[i].d_fill);
      chk($sformatf("v%0d_cwr", i), cwr_cnt - cw0, vecs[i].d_cwr);
      if (vecs[i].d_mwr != 0) begin
        chk($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].exp_maddr);
        chk($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].wdata);
      end
      if (vecs[i].d_mrd != 0) chk($sformatf("v%0d_rd_addr", i), last_rd_addr, vecs[i].exp_maddr);
    end
    gnt_delay = 0;

    // Abort: reset after beat 7 of a refill; nothing may be installed or completed.
    @(negedge clk);
    mrd0 = mem_rd_cnt; f0 = fill_cnt; ready_seen = 0;
    cpu_we = 0; cpu_addr = 32'h0000_0100; cpu_req = 1;
    reached = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (cpu_ready) ready_seen++;
      if (rd_pending && rd_beat >= 8) begin reached = 1; break; end
    end
    chk("abort_reached_beat8", reached, 1);
    rst = 1; cpu_req = 0;
    @(negedge clk);
    chk("abort_outputs_zero", outs_nonzero(), 0);
    @(negedge clk);
    rst = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ready) ready_seen++;
    end
    chk("abort_no_fill", fill_cnt - f0, 0);
    chk("abort_no_ready", ready_seen, 0);
    chk("abort_one_mem_read", mem_rd_cnt - mrd0, 1);

    do_req(0, 32'h0000_0100, 0, lat, rd);
    chk("reissue_rdata", rd, 32'hD0);
    chk("reissue_latency", lat, 22);
    chk("reissue_fills", fill_cnt - f0, 1);

    chk("never_wr_and_fill", both_err, 0);
    chk("cwr_only_on_write_hit", wr_rule_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
